// File: rtl/bit_count_engine_if.sv
// Request/result bundle for bit_count_engine.
//   master : start, clear, count_zeros, data_in out; result, busy, done in
//   slave  : the engine side of the same signals
interface bit_count_engine_if #(
  parameter int WIDTH = 8
);
  localparam int RW = $clog2(WIDTH + 1);

  logic             start;
  logic             clear;
  logic             count_zeros;
  logic [WIDTH-1:0] data_in;
  logic [RW-1:0]    result;
  logic             busy;
  logic             done;

  modport master (
    output start, clear, count_zeros, data_in,
    input  result, busy, done
  );

  modport slave (
    input  start, clear, count_zeros, data_in,
    output result, busy, done
  );
endinterface

// File: rtl/bit_count_engine.sv
// Bit-population counter: captures an operand on start, counts its 1s (or
// its 0s) by right-shifting, stops as soon as no set bits remain above bit 0,
// and holds the count with done high until start drops.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : bit_count_engine_if slave (start, clear, count_zeros, data_in,
//              result, busy, done)
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start; result holds the last count
// RUN   | shifting A right, accumulating A[0] into result
// DONE  | result valid; waits for start to go low
module bit_count_engine #(
  parameter int WIDTH = 8,
  parameter int RW    = $clog2(WIDTH + 1)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  bit_count_engine_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a;
  logic [RW-1:0]    result_q;

  // Reset asserts asynchronously but releases only after two clock edges,
  // so the FSM never sees a release that races the clock.
  logic rst_meta;
  logic rst_n;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = RUN;
        // Last cycle is the one where only bit 0 can still be set.
        RUN:     if (a[WIDTH-1:1] == '0) state_nxt = DONE;
        DONE:    if (!bus.start) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      result_q <= '0;
    end else if (bus.clear) begin
      a        <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Zeros mode is a ones count of the inverted operand.
            a        <= bus.count_zeros ? ~bus.data_in : bus.data_in;
            result_q <= '0;
          end
        end
        RUN: begin
          result_q <= result_q + {{(RW-1){1'b0}}, a[0]};
          a        <= a >> 1;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_bit_count_engine.sv
module tb_bit_count_engine;

  logic clk;
  logic reset;

  bit_count_engine_if #(.WIDTH(8))  b8 ();
  bit_count_engine_if #(.WIDTH(16)) b16 ();

  bit_count_engine #(.WIDTH(8)) dut8 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (b8)
  );

  bit_count_engine #(.WIDTH(16)) dut16 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (b16)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic       cz;
    int         exp_result;
    int         exp_run;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic run8(input vec_t v, input int idx);
    int edges;
    int runs;
    @(negedge clk);
    b8.data_in     = v.data;
    b8.count_zeros = v.cz;
    b8.start       = 1'b1;
    edges = 0;
    runs  = 0;
    while (!b8.done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (b8.busy) runs++;
    end
    check($sformatf("v%0d edges_to_done", idx), edges, v.exp_run + 1);
    check($sformatf("v%0d run_cycles", idx), runs, v.exp_run);
    check($sformatf("v%0d result", idx), int'(b8.result), v.exp_result);
    @(negedge clk);
    b8.start = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d idle_done", idx), int'(b8.done), 0);
    check($sformatf("v%0d idle_result_held", idx), int'(b8.result), v.exp_result);
  endtask

  initial begin
    vec_t vecs [10];
    int   edges;
    int   cnt;

    vecs[0] = '{8'h05, 1'b0, 2, 3};
    vecs[1] = '{8'hFF, 1'b0, 8, 8};
    vecs[2] = '{8'hFF, 1'b1, 0, 1};
    vecs[3] = '{8'h00, 1'b1, 8, 8};
    vecs[4] = '{8'h80, 1'b1, 7, 7};
    vecs[5] = '{8'hAA, 1'b0, 4, 8};
    vecs[6] = '{8'h01, 1'b0, 1, 1};
    vecs[7] = '{8'h00, 1'b0, 0, 1};
    vecs[8] = '{8'h81, 1'b1, 6, 7};
    vecs[9] = '{8'h10, 1'b0, 1, 5};

    reset           = 1'b0;
    b8.start        = 1'b0;
    b8.clear        = 1'b0;
    b8.count_zeros  = 1'b0;
    b8.data_in      = '0;
    b16.start       = 1'b0;
    b16.clear       = 1'b0;
    b16.count_zeros = 1'b0;
    b16.data_in     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset result", int'(b8.result), 0);
    check("reset busy", int'(b8.busy), 0);
    check("reset done", int'(b8.done), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_hold%0d", i),
            {29'd0, b8.busy, b8.done, 1'b0} | int'(b8.result), 0);
    end

    for (int i = 0; i < 10; i++) run8(vecs[i], i);

    // Inputs toggled during RUN must not disturb the count.
    @(negedge clk);
    b8.data_in = 8'hAA; b8.count_zeros = 1'b0; b8.start = 1'b1;
    edges = 0;
    while (!b8.done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      @(negedge clk);
      b8.data_in     = ~b8.data_in;
      b8.count_zeros = ~b8.count_zeros;
    end
    check("toggle edges_to_done", edges, 9);
    check("toggle result", int'(b8.result), 4);
    b8.start = 1'b0; b8.count_zeros = 1'b0;
    @(posedge clk); #1;
    check("toggle idle", int'(b8.done), 0);

    // Clear on the third RUN cycle.
    @(negedge clk);
    b8.data_in = 8'hAA; b8.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("clear pre busy", int'(b8.busy), 1);
    @(negedge clk);
    b8.clear = 1'b1;
    @(posedge clk); #1;
    check("clear busy", int'(b8.busy), 0);
    check("clear result", int'(b8.result), 0);
    @(negedge clk);
    b8.clear = 1'b0; b8.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (b8.done || b8.busy) cnt++;
    end
    check("clear no_done", cnt, 0);

    // Reset mid-RUN.
    @(negedge clk);
    b8.data_in = 8'hFF; b8.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrun busy", int'(b8.busy), 1);
    #3;
    reset = 1'b0;
    #1;
    check("midrun_reset result", int'(b8.result), 0);
    check("midrun_reset busy", int'(b8.busy), 0);
    check("midrun_reset done", int'(b8.done), 0);
    b8.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post midrun idle", int'(b8.busy) + int'(b8.done) + int'(b8.result), 0);

    // 16-bit all ones, then hold start in DONE.
    @(negedge clk);
    b16.data_in = 16'hFFFF; b16.count_zeros = 1'b0; b16.start = 1'b1;
    edges = 0;
    while (!b16.done && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    check("w16 edges_to_done", edges, 17);
    check("w16 result", int'(b16.result), 16);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (b16.done && !b16.busy) cnt++;
    end
    check("w16 done_held", cnt, 10);
    check("w16 result_held", int'(b16.result), 16);
    @(negedge clk);
    b16.start = 1'b0;
    @(posedge clk); #1;
    check("w16 idle", int'(b16.done), 0);
    check("w16 idle_result", int'(b16.result), 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_count_engine.md
Name: bit_count_engine

Overview:
- Parametrised bit-population counter with controller and datapath in one block.
- Captures a WIDTH-bit operand on start, counts its 1s or its 0s (mode-selectable) by right-shifting, and presents the count with a done flag.
- Terminates early once no set bits remain in the working register.
- Sits between a switch/register input stage and a display/result consumer on the CLOCK_50 domain.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- RW, $clog2(WIDTH+1), result width (derived; not overridden by users).

Ports:
- CLOCK_50  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserting low forces reset state immediately.
- start  input  1  level request; high in IDLE launches a count; must drop low to leave DONE.
- clear  input  1  synchronous abort; high forces IDLE and zeroes result on the next edge.
- count_zeros  input  1  0 = count 1s, 1 = count 0s; sampled only at launch.
- data_in  input  WIDTH  operand; sampled only at launch.
- result  output  RW  bit count; valid while done=1; held afterwards until next launch or clear.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.

Behaviour:
- Reset (reset low, async): state=IDLE, A=0, result=0, done=0, busy=0. Release is synchronised by the implementation; first state change no earlier than the first edge after release.
- Registers: state, A[WIDTH-1:0], result[RW-1:0]. done=(state==DONE), busy=(state==RUN). Both are pure Moore outputs.
- Precedence each edge: reset > clear > FSM.
- clear=1 in any state: next state=IDLE, result=0, A=0.
- IDLE:
  - start=0: hold everything; result keeps the previous count.
  - start=1: A <= count_zeros ? ~data_in : data_in; result <= 0; next state=RUN.
- RUN, every cycle:
  - result <= result + A[0]; A <= A >> 1 (zero fill).
  - If A[WIDTH-1:1]==0, next state=DONE; else stay in RUN.
  - start, data_in and count_zeros are ignored.
- DONE: result held.
  - start=0: next state=IDLE.
  - start=1: stay in DONE. No relaunch without start first going low.
- Latency: let k be the index of the highest set bit of the loaded A, with k=0 when A=0.
  - RUN lasts k+1 cycles.
  - done rises on edge k+2 after the edge that sampled start=1.
  - Worst case: WIDTH+1 edges. Best case (A=0 or A=1): 2 edges.
- Arithmetic: result never exceeds WIDTH, so there is no overflow in RW bits. All-ones operand in ones mode gives result=WIDTH.
- Zeros mode is exactly ones-count of ~data_in. Early termination applies to the inverted value.
- Reset asserted mid-RUN: immediate return to reset state; the partial count is discarded.

Test Plan:
- WIDTH=8, reset low then high, start=0 -> result=0, done=0, busy=0; hold 5 cycles, no change.
- WIDTH=8, data_in=8'b0000_0101, count_zeros=0, start=1 held -> busy high for 3 cycles, done rises on edge 4, result=2. Then start=0 -> IDLE next edge, done=0, result still 2.
- WIDTH=8, data_in=8'hFF, count_zeros=0 -> 8 RUN cycles, result=8. Same operand with count_zeros=1 -> 1 RUN cycle, result=0.
- WIDTH=8, data_in=8'h00, count_zeros=1 -> 8 RUN cycles, result=8. data_in=8'h80, count_zeros=1 -> loaded A=8'h7F, 7 RUN cycles, result=7.
- Launch 8'hAA in ones mode; toggle data_in and count_zeros during RUN -> result=4 unaffected. Assert clear on the 3rd RUN cycle -> IDLE next edge, result=0, done never asserts. Separately, pull reset low mid-RUN -> all outputs 0 immediately.
- WIDTH=16, data_in=16'hFFFF, ones mode -> done on edge 17, result=16 (5-bit). Holding start=1 in DONE for 10 cycles keeps done=1 and no relaunch.
